// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the async-read instruction memory and
// fills the IF/ID register, honouring stall, branch redirect and HALT.
module if_stage #(
    parameter int unsigned      ADDR_W     = 32,
    parameter int unsigned      DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013,
    parameter logic [DATA_W-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [DATA_W-1:0] if_id_instr,
    output logic              if_id_valid,
    output logic              halted,
    output logic [31:0]       fetch_count
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] if_id_pc_q, if_id_pc_d;
    logic [DATA_W-1:0] if_id_instr_q, if_id_instr_d;
    logic              if_id_valid_q, if_id_valid_d;
    logic [31:0]       fetch_count_q, fetch_count_d;

    logic is_halt;
    assign is_halt = (imem_rdata == HALT_INSTR);

    // State register: every flop of the stage, synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Next-state logic: a redirect always wins and also cancels a wrong-path HALT.
    always_comb begin
        state_d = state_q;
        if (branch_taken)
            state_d = RUN;
        else if (!stall && state_q == RUN && is_halt)
            state_d = HALTED;
    end

    // Datapath next values.
    always_comb begin
        // NOTE: hold defaults first so no path through this block infers a latch.
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        fetch_count_d = fetch_count_q;
        if (branch_taken) begin
            pc_d          = {branch_target[ADDR_W-1:2], 2'b00};
            if_id_pc_d    = '0;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
        end else if (!stall) begin
            if (state_q == RUN) begin
                if_id_pc_d    = pc_q;
                if_id_instr_d = imem_rdata;
                if_id_valid_d = 1'b1;
                fetch_count_d = fetch_count_q + 32'd1;
                // PC parks on the HALT word so a later redirect is the only way on.
                if (!is_halt)
                    pc_d = pc_q + ADDR_W'(4);
            end else begin
                if_id_pc_d    = '0;
                if_id_instr_d = NOP_INSTR;
                if_id_valid_d = 1'b0;
            end
        end
    end

    // Output logic.
    always_comb begin
        halted      = (state_q == HALTED);
        imem_addr   = pc_q;
        if_id_pc    = if_id_pc_q;
        if_id_instr = if_id_instr_q;
        if_id_valid = if_id_valid_q;
        fetch_count = fetch_count_q;
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch, stall, redirect, HALT, PC wrap and mid-halt reset.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken;
    logic [31:0] branch_target, imem_addr, imem_rdata;
    logic [31:0] if_id_pc, if_id_instr, fetch_count;
    logic        if_id_valid, halted;

    logic        w_rst;
    logic [31:0] w_imem_addr, w_imem_rdata, w_if_id_pc, w_if_id_instr, w_fetch_count;
    logic        w_if_id_valid, w_halted;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .halted(halted), .fetch_count(fetch_count)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(w_rst), .stall(1'b0), .branch_taken(1'b0),
        .branch_target(32'h0), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
        .if_id_pc(w_if_id_pc), .if_id_instr(w_if_id_instr), .if_id_valid(w_if_id_valid),
        .halted(w_halted), .fetch_count(w_fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                              input logic valid);
        check({tag, ".pc"}, if_id_pc, pc);
        check({tag, ".instr"}, if_id_instr, instr);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        imem_rdata = 32'h11; w_rst = 1'b1; w_imem_rdata = 32'h99;
        step();
        check("rst.addr", imem_addr, 32'h0);
        check_ifid("rst", 32'h0, NOP, 1'b0);
        check("rst.halted", {31'd0, halted}, 32'd0);
        check("rst.count", fetch_count, 32'd0);
        check("wrap.rst_addr", w_imem_addr, 32'hFFFF_FFFC);

        // Free-running fetch.
        rst = 1'b0; imem_rdata = 32'h11;
        step();
        check("run1.addr", imem_addr, 32'h4);
        check_ifid("run1", 32'h0, 32'h11, 1'b1);
        imem_rdata = 32'h22;
        step();
        check("run2.addr", imem_addr, 32'h8);
        check_ifid("run2", 32'h4, 32'h22, 1'b1);
        check("run2.count", fetch_count, 32'd2);

        // Stall two cycles at pc=8.
        stall = 1'b1; imem_rdata = 32'h33;
        step();
        step();
        check("stall.addr", imem_addr, 32'h8);
        check_ifid("stall", 32'h4, 32'h22, 1'b1);
        check("stall.count", fetch_count, 32'd2);
        stall = 1'b0;
        step();
        check("resume.addr", imem_addr, 32'hC);
        check_ifid("resume", 32'h8, 32'h33, 1'b1);
        imem_rdata = 32'h44;
        step();
        check("run4.addr", imem_addr, 32'h10);
        check("run4.count", fetch_count, 32'd4);

        // Branch with simultaneous stall: branch wins, target realigned.
        branch_taken = 1'b1; branch_target = 32'h103; stall = 1'b1; imem_rdata = 32'h55;
        step();
        check("br.addr", imem_addr, 32'h100);
        check_ifid("br", 32'h0, NOP, 1'b0);
        check("br.count", fetch_count, 32'd4);
        branch_taken = 1'b0; stall = 1'b0;
        step();
        check("br_fetch.addr", imem_addr, 32'h104);
        check_ifid("br_fetch", 32'h100, 32'h55, 1'b1);
        check("br_fetch.count", fetch_count, 32'd5);

        // HALT at 0x20.
        branch_taken = 1'b1; branch_target = 32'h20;
        step();
        branch_taken = 1'b0; imem_rdata = HALT;
        step();
        check_ifid("halt", 32'h20, HALT, 1'b1);
        check("halt.addr", imem_addr, 32'h20);
        check("halt.count", fetch_count, 32'd6);
        check("halt.halted", {31'd0, halted}, 32'd1);
        imem_rdata = 32'h66;
        step();
        check_ifid("halted_bubble", 32'h0, NOP, 1'b0);
        check("halted.addr", imem_addr, 32'h20);
        check("halted.count", fetch_count, 32'd6);
        check("halted.halted", {31'd0, halted}, 32'd1);
        branch_taken = 1'b1; branch_target = 32'h40;
        step();
        check("unhalt.halted", {31'd0, halted}, 32'd0);
        check("unhalt.addr", imem_addr, 32'h40);
        branch_taken = 1'b0; imem_rdata = 32'h77;
        step();
        check_ifid("unhalt_fetch", 32'h40, 32'h77, 1'b1);
        check("unhalt_fetch.count", fetch_count, 32'd7);

        // Halt again, then reset with a simultaneous branch.
        imem_rdata = HALT;
        step();
        check("halt2.halted", {31'd0, halted}, 32'd1);
        check("halt2.count", fetch_count, 32'd8);
        rst = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
        step();
        check("midrst.addr", imem_addr, 32'h0);
        check("midrst.halted", {31'd0, halted}, 32'd0);
        check_ifid("midrst", 32'h0, NOP, 1'b0);
        check("midrst.count", fetch_count, 32'd0);
        rst = 1'b0; branch_taken = 1'b0;

        // PC wrap on the second instance.
        w_rst = 1'b0;
        step();
        check("wrap.addr", w_imem_addr, 32'h0);
        check("wrap.ifid_pc", w_if_id_pc, 32'hFFFF_FFFC);
        check("wrap.instr", w_if_id_instr, 32'h99);
        check("wrap.count", w_fetch_count, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
